// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory controller: size encodings, FSM states
// and the request legality / store-lane helpers used by the controller.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // A request is legal when it is naturally aligned and stays inside the RAM.
  function automatic logic req_legal(input size_e size, input logic [31:0] addr,
                                     input int addr_w);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr[0];
      SZ_WORD: ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    if ((addr >> (addr_w + 2)) != 32'd0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] store_wea(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core-side request bus plus the data-RAM port of the memory controller.
// The master side is the core together with the RAM; the slave is dmem_ctrl.
interface dmem_ctrl_if #(parameter int ADDR_W = mips_mem_pkg::ADDR_W_DEF);

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;
  logic              ram_ena;
  logic [3:0]        ram_wea;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output req, we, size, sext, addr, wdata, ram_rdata,
    input  busy, ack, err, rdata, ram_ena, ram_wea, ram_addr, ram_wdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata, ram_rdata,
    output busy, ack, err, rdata, ram_ena, ram_wea, ram_addr, ram_wdata
  );

endinterface

// File: rtl/dmem_ctrl_load_align.sv
// Load formatting: picks the addressed byte/half out of a little-endian RAM
// word, right-justifies it and sign- or zero-extends it.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = 8'h00;
    half_val = 16'h0000;
    data     = word;
    case (addr_lo)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    half_val = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{sext & byte_val[7]}}, byte_val};
      SZ_HALF: data = {{16{sext & half_val[15]}}, half_val};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns core byte/half/word requests into single-cycle
// RAM accesses and returns a formatted response two cycles after acceptance.
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  dmem_ctrl_if.slave bus
);

  state_e            state, state_nx;
  logic              legal;
  logic              accept;

  logic              ena_d, ack_d, err_d;
  logic [3:0]        wea_d;

  logic              ena_q, ack_q, err_q;
  logic [3:0]        wea_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic [31:0]       rdata_q;

  logic              we_q;
  size_e             size_q;
  logic              sext_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       load_fmt;

  assign legal  = req_legal(size_e'(bus.size), bus.addr, ADDR_W);
  assign accept = (state == ST_IDLE) && bus.req && legal;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.req && legal) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; illegal requests answer straight from IDLE.
  always_comb begin
    ena_d = 1'b0;
    wea_d = 4'b0000;
    ack_d = 1'b0;
    err_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (legal) begin
            ena_d = 1'b1;
            wea_d = bus.we ? store_wea(size_e'(bus.size), bus.addr[1:0]) : 4'b0000;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_ACCESS: ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ena_q       <= 1'b0;
      wea_q       <= 4'b0000;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sext_q      <= 1'b0;
      addr_lo_q   <= 2'b00;
    end else begin
      ena_q <= ena_d;
      wea_q <= wea_d;
      ack_q <= ack_d;
      err_q <= err_d;
      if (accept) begin
        ram_addr_q <= bus.addr[ADDR_W+1:2];
        we_q       <= bus.we;
        size_q     <= size_e'(bus.size);
        sext_q     <= bus.sext;
        addr_lo_q  <= bus.addr[1:0];
        if (bus.we) ram_wdata_q <= store_data(size_e'(bus.size), bus.wdata);
      end
      if (state == ST_RESP && !we_q) rdata_q <= load_fmt;
    end
  end

  load_align u_align (
    .word    (bus.ram_rdata),
    .addr_lo (addr_lo_q),
    .size    (size_q),
    .sext    (sext_q),
    .data    (load_fmt)
  );

  // Reset gates the enables and ack so a request caught by reset never commits.
  assign bus.ram_ena   = ena_q & rst;
  assign bus.ram_wea   = wea_q & {4{rst}};
  assign bus.ack       = ack_q & rst;
  assign bus.err       = err_q & rst;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rdata     = (state == ST_RESP && !we_q) ? load_fmt : rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a small synchronous read-first RAM model.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   ena_count = 0;

  logic [31:0] mem [0:1023];

  dmem_ctrl_if #(.ADDR_W(10)) bus ();

  dmem_ctrl #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_ena === 1'b1) begin
      for (int i = 0; i < 4; i++)
        if (bus.ram_wea[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
      bus.ram_rdata <= mem[bus.ram_addr];
      ena_count <= ena_count + 1;
    end
  end

  // Drives one request for a single edge; returns mid-cycle just after acceptance.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.we = we; bus.size = size; bus.sext = sext; bus.addr = addr; bus.wdata = wdata;
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic finish_access();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", bus.ack); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.err); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.rdata); end
    total++; if (bus.ram_ena !== 1'b0 || bus.ram_wea !== 4'h0) begin bad++; $display("[TB] FAIL reset_ram_en: got %b/%b want 0/0", bus.ram_ena, bus.ram_wea); end
    total++; if (bus.ram_addr !== 10'h0 || bus.ram_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_ram_bus: got %h/%h want 0/0", bus.ram_addr, bus.ram_wdata); end
    rst = 1'b1;
  endtask

  task automatic test_store_word();
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    total++; if (bus.ram_ena !== 1'b1 || bus.ram_wea !== 4'b1111) begin bad++; $display("[TB] FAIL sw_access_en: got %b/%b want 1/1111", bus.ram_ena, bus.ram_wea); end
    total++; if (bus.ram_addr !== 10'd4) begin bad++; $display("[TB] FAIL sw_addr: got %0d want 4", bus.ram_addr); end
    total++; if (bus.ram_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL sw_wdata: got %h want deadbeef", bus.ram_wdata); end
    total++; if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin bad++; $display("[TB] FAIL sw_n1: got busy=%b ack=%b want 1/0", bus.busy, bus.ack); end
    @(negedge clk);
    total++; if (bus.ack !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("[TB] FAIL sw_ack: got ack=%b err=%b want 1/0", bus.ack, bus.err); end
    total++; if (bus.ram_ena !== 1'b0 || bus.ram_wea !== 4'h0) begin bad++; $display("[TB] FAIL sw_resp_en: got %b/%b want 0/0", bus.ram_ena, bus.ram_wea); end
    @(negedge clk);
    total++; if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL sw_n3: got ack=%b busy=%b want 0/0", bus.ack, bus.busy); end
    total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL sw_mem: got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_load_format();
    logic [1:0]  sz  [7];
    logic        sx  [7];
    logic [31:0] ad  [7];
    logic [31:0] exp_d [7];
    sz = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    sx = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ad = '{32'h13, 32'h13, 32'h10, 32'h11, 32'h12, 32'h10, 32'h10};
    exp_d = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFFFBB, 32'h000000AA,
              32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    finish_access();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, sz[i], sx[i], ad[i], 32'h0);
      total++; if (bus.ram_ena !== 1'b1 || bus.ram_wea !== 4'h0) begin bad++; $display("[TB] FAIL ld%0d_access: got %b/%b want 1/0000", i, bus.ram_ena, bus.ram_wea); end
      @(negedge clk);
      total++; if (bus.ack !== 1'b1 || bus.rdata !== exp_d[i]) begin bad++; $display("[TB] FAIL ld%0d_resp: got ack=%b rdata=%h want 1/%h", i, bus.ack, bus.rdata, exp_d[i]); end
      @(negedge clk);
      total++; if (bus.ack !== 1'b0 || bus.rdata !== exp_d[i]) begin bad++; $display("[TB] FAIL ld%0d_hold: got ack=%b rdata=%h want 0/%h", i, bus.ack, bus.rdata, exp_d[i]); end
    end
  endtask

  task automatic test_store_sub_word();
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    total++; if (bus.ram_wea !== 4'b1100 || bus.ram_wdata !== 32'h12341234) begin bad++; $display("[TB] FAIL sh_lanes: got %b/%h want 1100/12341234", bus.ram_wea, bus.ram_wdata); end
    finish_access();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    total++; if (bus.rdata !== 32'h1234AABB) begin bad++; $display("[TB] FAIL sh_readback: got %h want 1234aabb", bus.rdata); end
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
    total++; if (bus.ram_wea !== 4'b0010 || bus.ram_wdata !== 32'h55555555) begin bad++; $display("[TB] FAIL sb_lanes: got %b/%h want 0010/55555555", bus.ram_wea, bus.ram_wdata); end
    finish_access();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    total++; if (bus.rdata !== 32'h123455BB) begin bad++; $display("[TB] FAIL sb_readback: got %h want 123455bb", bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic        we_t [5];
    logic [1:0]  sz   [5];
    logic [31:0] ad   [5];
    int          ena0;
    we_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sz   = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b10};
    ad   = '{32'h06, 32'h00, 32'h1000, 32'h01, 32'h1000};
    for (int i = 0; i < 5; i++) begin
      ena0 = ena_count;
      applyStimulus(we_t[i], sz[i], 1'b0, ad[i], 32'hA5A5A5A5);
      total++; if (bus.ack !== 1'b1 || bus.err !== 1'b1) begin bad++; $display("[TB] FAIL ill%0d_ack: got ack=%b err=%b want 1/1", i, bus.ack, bus.err); end
      total++; if (bus.busy !== 1'b0 || bus.rdata !== 32'h123455BB) begin bad++; $display("[TB] FAIL ill%0d_state: got busy=%b rdata=%h want 0/123455bb", i, bus.busy, bus.rdata); end
      @(negedge clk);
      total++; if (bus.ack !== 1'b0 || ena_count !== ena0) begin bad++; $display("[TB] FAIL ill%0d_noaccess: got ack=%b accesses=%0d want 0/%0d", i, bus.ack, ena_count, ena0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ack_mask;
    logic [9:0] ena_mask;
    ack_mask = '0;
    ena_mask = '0;
    @(negedge clk);
    bus.we = 1'b0; bus.size = 2'b10; bus.sext = 1'b0; bus.addr = 32'h10; bus.req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ack_mask[i] = bus.ack;
      ena_mask[i] = bus.ram_ena;
      if (i == 4) bus.req = 1'b0;
    end
    total++; if (ena_mask !== 10'b00_0000_1001) begin bad++; $display("[TB] FAIL b2b_access: got %b want 0000001001", ena_mask); end
    total++; if (ack_mask !== 10'b00_0001_0010) begin bad++; $display("[TB] FAIL b2b_ack: got %b want 0000010010", ack_mask); end
    total++; if (bus.rdata !== 32'h123455BB) begin bad++; $display("[TB] FAIL b2b_rdata: got %h want 123455bb", bus.rdata); end
  endtask

  task automatic test_reset_mid_store();
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
    total++; if (bus.ram_ena !== 1'b1) begin bad++; $display("[TB] FAIL rs_access: got %b want 1", bus.ram_ena); end
    rst = 1'b0;
    #1;
    total++; if (bus.ram_ena !== 1'b0 || bus.ram_wea !== 4'h0) begin bad++; $display("[TB] FAIL rs_gate: got %b/%b want 0/0", bus.ram_ena, bus.ram_wea); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.ack !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("[TB] FAIL rs_ctrl: got busy=%b ack=%b err=%b want 0/0/0", bus.busy, bus.ack, bus.err); end
    total++; if (bus.rdata !== 32'h0 || bus.ram_addr !== 10'h0 || bus.ram_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rs_data: got %h/%h/%h want 0/0/0", bus.rdata, bus.ram_addr, bus.ram_wdata); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rs_noack: got ack=%b busy=%b want 0/0", bus.ack, bus.busy); end
    total++; if (mem[4] !== 32'h123455BB) begin bad++; $display("[TB] FAIL rs_mem: got %h want 123455bb", mem[4]); end
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    total++; if (bus.ack !== 1'b1 || bus.rdata !== 32'h123455BB) begin bad++; $display("[TB] FAIL rs_reload: got ack=%b rdata=%h want 1/123455bb", bus.ack, bus.rdata); end
    @(negedge clk);
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    test_reset();
    test_store_word();
    test_load_format();
    test_store_sub_word();
    test_illegal();
    test_back_to_back();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, word-address width driven to the data RAM.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req  in  1  core memory request, sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load; sampled with req.
REQ-006 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 sext  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
REQ-008 addr  in  32  byte address (core ALU result).
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 ack  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with ack; misaligned, out-of-range or reserved-size request.
REQ-013 rdata  out  32  formatted load data, valid with ack, held until next ack.
REQ-014 ram_ena  out  1  data RAM enable.
REQ-015 ram_wea  out  4  data RAM byte write enables, bit i = bits [8i+7:8i].
REQ-016 ram_addr  out  ADDR_W  RAM word address = addr[ADDR_W+1:2].
REQ-017 ram_wdata  out  32  lane-replicated store data.
REQ-018 ram_rdata  in  32  RAM read data, valid one cycle after ram_ena.

Function
REQ-019 FSM states are IDLE, ACCESS, RESP; all outputs except rdata formatting are registered.
REQ-020 IDLE with req=1 and a legal request latches we/size/sext/addr/wdata and enters ACCESS next cycle.
REQ-021 ACCESS drives ram_ena=1 for exactly one cycle; stores also drive ram_wea and ram_wdata in that cycle; the next state is RESP.
REQ-022 RESP asserts ack=1, err=0 for one cycle, loads rdata from the formatted ram_rdata, and returns to IDLE.
REQ-023 Latency is req accepted at edge N -> ack high in cycle N+2, for both loads and stores; throughput is one request per 3 cycles.
REQ-024 Illegal request: half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr[31:ADDR_W+2]!=0.
REQ-025 An illegal request raises ack=1, err=1 in the cycle after acceptance, issues no RAM access, leaves rdata unchanged, and keeps the state in IDLE.
REQ-026 req asserted while busy=1 is ignored and is not queued.
REQ-027 Lanes are little-endian; the byte at addr[1:0]=k is bits [8k+7:8k].
REQ-028 Store byte: ram_wdata={4{wdata[7:0]}}, ram_wea=4'b0001<<addr[1:0].
REQ-029 Store half: ram_wdata={2{wdata[15:0]}}, ram_wea=0011 (addr[1]=0) or 1100 (addr[1]=1).
REQ-030 Store word: ram_wdata=wdata, ram_wea=1111.
REQ-031 Loads keep ram_wea=0000; the selected byte/half is right-justified and extended per sext; word loads pass through unchanged.
REQ-032 ram_ena and ram_wea are 0 in every cycle other than ACCESS.

Reset
REQ-033 rst=0 at an edge forces, at that edge: state IDLE, busy=0, ack=0, err=0, rdata=0, ram_ena=0, ram_wea=0, ram_addr=0, ram_wdata=0.
REQ-034 Reset in ACCESS or RESP abandons the request: no ack is produced, and any RAM write still pending at that edge is suppressed.

Structure
REQ-035 Package mips_mem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding and ADDR_W default.
REQ-036 One combinational sub-module, load_align, performs lane extraction and extension (inputs: word, addr[1:0], size, sext).

Verification
REQ-037 Store word addr=0x10, wdata=0xDEADBEEF -> ram_wea=1111, ram_addr=4 in ACCESS; ack at N+2, err=0.
REQ-038 With RAM word 4 = 0x8899AABB: load byte addr=0x13 with sext=1 -> rdata=0xFFFFFF88; the same load with sext=0 -> 0x00000088.
REQ-039 Store half addr=0x12, wdata=0x1234 -> ram_wea=1100, ram_wdata=0x12341234; a following word load from 0x10 -> 0x1234xxxx with the low half unchanged.
REQ-040 Load word addr=0x06 -> ack=1, err=1 at N+1, ram_ena never asserted, rdata unchanged; size=11 and addr=0x00001000 give the same result.
REQ-041 req held high for 5 cycles -> exactly one access accepted, plus a second access accepted on the cycle after ack.
REQ-042 rst=0 while in ACCESS of a store -> no ack, RAM contents unchanged, all outputs equal their reset values next cycle.
